// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register-file scoreboard slice.
// Holds the register-file geometry and the x0 index constant used by the
// scoreboard top and its write-back arbiter.
package regfile_scoreboard_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_REGS  = 32;

  // x0 is hard-wired to zero: never tracked, never written.
  localparam logic [REG_IDX_W-1:0] X0_IDX = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// The short write-back path has absolute priority and no backpressure. The long
// completion path is accepted only when no short write is present. A counter of
// consecutive denied long requests raises starve once it reaches STARVE_LIMIT.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   sw_valid/sw_rd/sw_data  short write-back request
//   lw_valid/lw_rd/lw_data  long completion request, lw_ready grants it
//   lw_fire                 long handshake this cycle
//   rf_we/rf_wa/rf_wd       register-file write port
//   starve                  long path starved; issue must freeze
module regfile_wb_arbiter
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sw_valid,
  input  logic [REG_IDX_W-1:0] sw_rd,
  input  logic [XLEN-1:0]      sw_data,
  input  logic                 lw_valid,
  input  logic [REG_IDX_W-1:0] lw_rd,
  input  logic [XLEN-1:0]      lw_data,
  output logic                 lw_ready,
  output logic                 lw_fire,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_wa,
  output logic [XLEN-1:0]      rf_wd,
  output logic                 starve
);

  localparam int unsigned STALL_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STARVE_LIMIT);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Priority mux: short write-back wins, long completion fills idle slots.
  always_comb begin
    lw_ready = ~sw_valid;
    lw_fire  = lw_valid & ~sw_valid;
    rf_we    = 1'b0;
    rf_wa    = X0_IDX;
    rf_wd    = {XLEN{1'b0}};
    if (sw_valid) begin
      rf_we = (sw_rd != X0_IDX);
      rf_wa = sw_rd;
      rf_wd = sw_data;
    end else if (lw_valid) begin
      rf_we = (lw_rd != X0_IDX);
      rf_wa = lw_rd;
      rf_wd = lw_data;
    end else begin
      rf_we = 1'b0;
    end
  end

  // Starvation counter next state: count denied cycles, saturate, clear otherwise.
  always_comb begin
    stall_cnt_d = {STALL_W{1'b0}};
    if (lw_valid & ~lw_ready) begin
      if (stall_cnt_q == STALL_MAX) begin
        stall_cnt_d = stall_cnt_q;
      end else begin
        stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
    end else begin
      stall_cnt_d = {STALL_W{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {STALL_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign starve = (stall_cnt_q == STALL_MAX);

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard for the 32x32 2R1W register file.
// Tracks destinations of in-flight long-latency ops in a pending bitmap, stalls
// issue on RAW/WAW hazards, caps outstanding long ops at MAX_LONG and freezes
// issue while the long completion path is starved at the write port.
// Ports:
//   iss_*      decode-side instruction and iss_ready handshake
//   sw_*       short write-back (no backpressure)
//   lw_*       long completion with lw_ready handshake
//   rf_*       register-file write port
//   pending    pending bitmap (bit 0 always 0)
//   outstanding in-flight long op count
//   err        sticky protocol error
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_LONG     = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = $clog2(MAX_LONG + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  input  logic                 iss_rs1_used,
  input  logic                 iss_rs2_used,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic                 iss_rd_we,
  input  logic                 iss_long,
  input  logic                 sw_valid,
  input  logic [REG_IDX_W-1:0] sw_rd,
  input  logic [XLEN-1:0]      sw_data,
  input  logic                 lw_valid,
  output logic                 lw_ready,
  input  logic [REG_IDX_W-1:0] lw_rd,
  input  logic [XLEN-1:0]      lw_data,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_wa,
  output logic [XLEN-1:0]      rf_wd,
  output logic [NUM_REGS-1:0]  pending,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LONG);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                err_q, err_d;

  logic starve, lw_fire;
  logic raw, waw, full, long_fire, at_max, at_zero, inc, dec;

  regfile_wb_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_wb_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_valid (sw_valid),
    .sw_rd    (sw_rd),
    .sw_data  (sw_data),
    .lw_valid (lw_valid),
    .lw_rd    (lw_rd),
    .lw_data  (lw_data),
    .lw_ready (lw_ready),
    .lw_fire  (lw_fire),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .starve   (starve)
  );

  // Hazard detection and issue handshake; registered state only, no bypass.
  always_comb begin
    at_max    = (outstanding_q == MAX_CNT);
    at_zero   = (outstanding_q == {CNT_W{1'b0}});
    raw       = (iss_rs1_used & (iss_rs1 != X0_IDX) & pending_q[iss_rs1]) |
                (iss_rs2_used & (iss_rs2 != X0_IDX) & pending_q[iss_rs2]);
    waw       = iss_rd_we & (iss_rd != X0_IDX) & pending_q[iss_rd];
    full      = iss_long & at_max;
    iss_ready = ~raw & ~waw & ~full & ~starve;
    long_fire = iss_valid & iss_ready & iss_long;
    inc       = long_fire & ~at_max;
    dec       = lw_fire & ~at_zero;
  end

  // Scoreboard next state: bitmap set/clear, saturating counter, sticky error.
  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    // WAW blocks issue to a pending rd, so set and clear never hit one bit together.
    if (long_fire & iss_rd_we & (iss_rd != X0_IDX)) begin
      pending_d[iss_rd] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    if (lw_fire & (lw_rd != X0_IDX)) begin
      pending_d[lw_rd] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    pending_d[X0_IDX] = 1'b0;
    case ({inc, dec})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if ((lw_fire & at_zero) |
        (lw_fire & (lw_rd != X0_IDX) & ~pending_q[lw_rd]) |
        (long_fire & at_max)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Scoreboard state registers; reset discards all in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= {NUM_REGS{1'b0}};
      outstanding_q <= {CNT_W{1'b0}};
      err_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a stimulus process drives inputs on
// the falling edge and pushes the reference model's expected outputs into a
// queue; a monitor pops and compares a little after each falling edge.
module tb_regfile_scoreboard;

  localparam int MAX_LONG     = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk, rst_n;
  logic        iss_valid, iss_ready, iss_rs1_used, iss_rs2_used, iss_rd_we, iss_long;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd, sw_rd, lw_rd, rf_wa;
  logic        sw_valid, lw_valid, lw_ready, rf_we, err;
  logic [31:0] sw_data, lw_data, rf_wd, pending;
  logic [2:0]  outstanding;

  regfile_scoreboard #(.MAX_LONG(MAX_LONG), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_used(iss_rs1_used), .iss_rs2_used(iss_rs2_used),
    .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_long(iss_long),
    .sw_valid(sw_valid), .sw_rd(sw_rd), .sw_data(sw_data),
    .lw_valid(lw_valid), .lw_ready(lw_ready), .lw_rd(lw_rd), .lw_data(lw_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pending(pending), .outstanding(outstanding), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rdy;
    bit          lrdy;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pend;
    int          outs;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: the architectural meaning of the scoreboard state.
  bit   pend_m[32];
  int   out_m, stall_m;
  bit   err_m;
  int   inflight[$];   // destinations of issued long ops, oldest first (0 = no writeback)

  // Staged stimulus, applied at the next falling edge by cycle().
  bit         s_rst, s_iv, s_u1, s_u2, s_we, s_lng, s_sv, s_lv;
  logic [4:0] s_rs1, s_rs2, s_rd, s_srd, s_lrd;
  logic [31:0] s_sd, s_ld;

  task automatic clr();
    s_rst = 1'b1; s_iv = 1'b0; s_u1 = 1'b0; s_u2 = 1'b0; s_we = 1'b0; s_lng = 1'b0;
    s_sv = 1'b0; s_lv = 1'b0; s_rs1 = 5'd0; s_rs2 = 5'd0; s_rd = 5'd0;
    s_srd = 5'd0; s_lrd = 5'd0; s_sd = 32'd0; s_ld = 32'd0;
  endtask

  task automatic cycle();
    exp_t e;
    bit raw, waw, full, starve, fire, hand, inc, dec;
    @(negedge clk);
    rst_n = s_rst; iss_valid = s_iv; iss_rs1 = s_rs1; iss_rs2 = s_rs2;
    iss_rs1_used = s_u1; iss_rs2_used = s_u2; iss_rd = s_rd; iss_rd_we = s_we;
    iss_long = s_lng; sw_valid = s_sv; sw_rd = s_srd; sw_data = s_sd;
    lw_valid = s_lv; lw_rd = s_lrd; lw_data = s_ld;
    if (!s_rst) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      out_m = 0; stall_m = 0; err_m = 1'b0;
      inflight.delete();
    end
    starve = (stall_m == STARVE_LIMIT);
    raw  = (s_u1 && s_rs1 != 5'd0 && pend_m[s_rs1]) || (s_u2 && s_rs2 != 5'd0 && pend_m[s_rs2]);
    waw  = s_we && s_rd != 5'd0 && pend_m[s_rd];
    full = s_lng && out_m == MAX_LONG;
    e.rdy  = !(raw || waw || full || starve);
    e.lrdy = !s_sv;
    if (s_sv) begin
      e.we = (s_srd != 5'd0); e.wa = s_srd; e.wd = s_sd;
    end else if (s_lv) begin
      e.we = (s_lrd != 5'd0); e.wa = s_lrd; e.wd = s_ld;
    end else begin
      e.we = 1'b0; e.wa = 5'd0; e.wd = 32'd0;
    end
    for (int i = 0; i < 32; i++) e.pend[i] = pend_m[i];
    e.outs = out_m;
    e.err  = err_m;
    exp_q.push_back(e);
    if (s_rst) begin
      fire = s_iv && e.rdy;
      hand = s_lv && !s_sv;
      if (hand && out_m == 0) err_m = 1'b1;
      if (hand && s_lrd != 5'd0 && !pend_m[s_lrd]) err_m = 1'b1;
      if (fire && s_lng && out_m == MAX_LONG) err_m = 1'b1;
      if (hand && s_lrd != 5'd0) pend_m[s_lrd] = 1'b0;
      if (fire && s_lng && s_we && s_rd != 5'd0) pend_m[s_rd] = 1'b1;
      inc = fire && s_lng && out_m < MAX_LONG;
      dec = hand && out_m > 0;
      out_m = out_m + (inc ? 1 : 0) - (dec ? 1 : 0);
      if (s_lv && s_sv) stall_m = (stall_m < STARVE_LIMIT) ? stall_m + 1 : STARVE_LIMIT;
      else stall_m = 0;
      if (fire && s_lng) inflight.push_back((s_we && s_rd != 5'd0) ? int'(s_rd) : 0);
      if (hand && inflight.size() > 0 && int'(s_lrd) == inflight[0]) void'(inflight.pop_front());
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared after outputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("iss_ready",   {31'd0, iss_ready}, {31'd0, e.rdy});
        chk("lw_ready",    {31'd0, lw_ready},  {31'd0, e.lrdy});
        chk("rf_we",       {31'd0, rf_we},     {31'd0, e.we});
        chk("rf_wa",       {27'd0, rf_wa},     {27'd0, e.wa});
        chk("rf_wd",       rf_wd,              e.wd);
        chk("pending",     pending,            e.pend);
        chk("outstanding", {29'd0, outstanding}, 32'(e.outs));
        chk("err",         {31'd0, err},       {31'd0, e.err});
      end
    end
  end

  task automatic issue(input bit lng, input logic [4:0] rd, input bit we);
    clr(); s_iv = 1'b1; s_lng = lng; s_rd = rd; s_we = we; cycle();
  endtask

  task automatic complete(input logic [4:0] rd);
    clr(); s_lv = 1'b1; s_lrd = rd; s_ld = 32'h1000_0000 | 32'(rd); cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    s_rst = 1'b0; cycle(); cycle();
    clr(); cycle();

    // Load to x5, dependent read stalls, completion clears.
    issue(1'b1, 5'd5, 1'b1);
    clr(); s_iv = 1'b1; s_rs1 = 5'd5; s_u1 = 1'b1; cycle();
    complete(5'd5);
    clr(); s_iv = 1'b1; s_rs1 = 5'd5; s_u1 = 1'b1; cycle();

    // WAW stall, then independent op issues.
    issue(1'b1, 5'd5, 1'b1);
    issue(1'b0, 5'd5, 1'b1);
    clr(); s_iv = 1'b1; s_rs1 = 5'd6; s_rs2 = 5'd7; s_u1 = 1'b1; s_u2 = 1'b1; cycle();
    complete(5'd5);

    // Fill to MAX_LONG, full blocks only long ops, simultaneous issue+complete.
    for (int r = 1; r <= 4; r++) issue(1'b1, 5'(r), 1'b1);
    issue(1'b1, 5'd11, 1'b1);
    issue(1'b0, 5'd9, 1'b1);
    complete(5'd4);
    clr(); s_iv = 1'b1; s_lng = 1'b1; s_rd = 5'd6; s_we = 1'b1;
    s_lv = 1'b1; s_lrd = 5'd1; s_ld = 32'h55; cycle();
    complete(5'd2); complete(5'd3); complete(5'd6);

    // Short write-back beats long completion.
    issue(1'b1, 5'd8, 1'b1);
    clr(); s_sv = 1'b1; s_srd = 5'd3; s_sd = 32'hAAAA_0000;
    s_lv = 1'b1; s_lrd = 5'd8; s_ld = 32'h0000_1234; cycle();
    clr(); s_lv = 1'b1; s_lrd = 5'd8; s_ld = 32'h0000_1234; cycle();

    // Starvation freezes issue until the long completion gets through.
    issue(1'b1, 5'd10, 1'b1);
    for (int c = 0; c < 11; c++) begin
      clr(); s_iv = 1'b1; s_sv = 1'b1; s_srd = 5'd3; s_sd = 32'(c);
      s_lv = 1'b1; s_lrd = 5'd10; s_ld = 32'hBEEF; cycle();
    end
    complete(5'd10);
    issue(1'b0, 5'd9, 1'b1);
    issue(1'b0, 5'd9, 1'b1);

    // Protocol errors, x0 completion, mid-stream reset.
    complete(5'd12);
    clr(); cycle();
    issue(1'b1, 5'd0, 1'b0);
    complete(5'd0);
    issue(1'b1, 5'd7, 1'b1);
    clr(); s_rst = 1'b0; cycle();
    clr(); cycle();

    // Randomized traffic with occasional resets and stray completions.
    for (int n = 0; n < 3000; n++) begin
      clr();
      if ($urandom_range(0, 299) == 0) begin
        s_rst = 1'b0; cycle();
        continue;
      end
      s_iv  = ($urandom_range(0, 3) != 0);
      s_rs1 = 5'($urandom_range(0, 7)); s_u1 = ($urandom_range(0, 1) == 1);
      s_rs2 = 5'($urandom_range(0, 7)); s_u2 = ($urandom_range(0, 1) == 1);
      s_rd  = 5'($urandom_range(0, 7)); s_we = ($urandom_range(0, 3) != 0);
      s_lng = ($urandom_range(0, 1) == 1);
      s_sv  = ($urandom_range(0, 3) == 0);
      s_srd = 5'($urandom_range(0, 31)); s_sd = $urandom;
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        s_lv = 1'b1; s_lrd = 5'(inflight[0]); s_ld = $urandom;
      end else if ($urandom_range(0, 99) == 0) begin
        s_lv = 1'b1; s_lrd = 5'($urandom_range(0, 31)); s_ld = $urandom;
      end
      cycle();
    end

    clr(); cycle();
    @(negedge clk);
    #5;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Issue-side controller for the 32x32 two-read/one-write register file of the RISC-V core.
- Tracks destination registers of in-flight long-latency ops (loads, mul/div) in a pending bitmap.
- Stalls issue on RAW/WAW hazards against pending registers, and limits the number of outstanding long ops.
- Arbitrates the single register-file write port between the fixed-latency short writeback path and the variable-latency long-op completion path, with a starvation guard.

Parameters:
- MAX_LONG, 4: maximum outstanding long ops (1..15).
- STARVE_LIMIT, 8: consecutive denied long-completion cycles before issue is frozen (>=1).
- CNT_W, $clog2(MAX_LONG+1): width of the outstanding counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- iss_valid  in  1  decode presents an instruction.
- iss_ready  out  1  instruction may issue this cycle.
- iss_rs1, iss_rs2  in  5 each  source register indices.
- iss_rs1_used, iss_rs2_used  in  1 each  source is actually read.
- iss_rd  in  5  destination register index.
- iss_rd_we  in  1  instruction writes rd.
- iss_long  in  1  instruction is a long-latency op.
- sw_valid  in  1  short writeback this cycle; no backpressure.
- sw_rd  in  5  short writeback register.
- sw_data  in  32  short writeback data.
- lw_valid  in  1  long-op completion request.
- lw_ready  out  1  long completion accepted.
- lw_rd  in  5  long completion register.
- lw_data  in  32  long completion data.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  32  register-file write data.
- pending  out  32  pending bitmap; bit 0 is always 0.
- outstanding  out  CNT_W  number of in-flight long ops.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0): pending=0, outstanding=0, stall counter=0, starve=0, err=0. Outputs are then combinational from this cleared state.
- Reset mid-operation discards all in-flight tracking. Long units must be reset by the same rst_n.
- Hazard terms use registered state only; there is no same-cycle bypass of clears.
  - raw = (rs1_used & rs1!=0 & pending[rs1]) | (rs2_used & rs2!=0 & pending[rs2])
  - waw = rd_we & rd!=0 & pending[rd]
  - full = iss_long & (outstanding==MAX_LONG)
- iss_ready = !raw & !waw & !full & !starve. It is independent of iss_valid.
- Issue fire = iss_valid & iss_ready.
  - Fire with iss_long: outstanding+1. If rd_we & rd!=0, also set pending[rd] at the clock edge.
  - Short ops never touch pending.
- Every long op produces exactly one lw handshake. An op with no writeback uses lw_rd=0.
- Write-port arbitration (combinational):
  - sw has absolute priority; lw_ready = !sw_valid.
  - Winner drives rf_wa/rf_wd. rf_we = winner_valid & winner_rd!=0.
  - When idle: rf_we=0, rf_wa=0, rf_wd=0.
- Long handshake (lw_valid & lw_ready) at the edge:
  - clear pending[lw_rd] (no-op for rd 0);
  - outstanding-1.
  - Simultaneous issue-long fire and lw handshake leaves outstanding unchanged.
  - Set and clear of the same bit in one cycle cannot occur, because WAW blocks issue.
- Starvation guard:
  - stall_cnt increments each cycle lw_valid & !lw_ready, saturating at STARVE_LIMIT.
  - stall_cnt clears on lw handshake or when lw_valid=0.
  - starve = (stall_cnt==STARVE_LIMIT); it forces iss_ready=0 until the handshake clears the counter.
- err is set, sticky until reset, on any of:
  - lw handshake with outstanding==0;
  - lw handshake with lw_rd!=0 and pending[lw_rd]==0;
  - issue-long fire while outstanding==MAX_LONG (unreachable if iss_ready is honoured).
- Counter never wraps: saturate and flag err instead.

Decomposition:
- Shared core package holds:
  - REG_IDX_W=5, XLEN=32, NUM_REGS=32;
  - the x0 index constant.
- One natural sub-module: regfile_wb_arbiter. It contains the sw/lw priority mux, lw_ready, and the starvation counter, and exports starve.
- Scoreboard bitmap, counter and err logic stay in the top module.

Test Plan:
- Reset, then issue long load rd=5 -> pending=0x20, outstanding=1. Next instr with rs1=5, rs1_used=1 -> iss_ready=0. lw handshake rd=5 -> next cycle pending=0, iss_ready=1.
- Issue short op rd=5 while pending[5]=1 -> iss_ready=0 (WAW). Same instr with rd_we=0 and sources 6/7 -> iss_ready=1.
- Issue 4 long ops to rd=1..4 (MAX_LONG=4) -> outstanding=4, 5th long iss_ready=0, short op to rd=9 still issues. Same-cycle long issue and lw rd=1 from outstanding=3 -> stays 3.
- sw_valid=1 (rd=3, data 0xAAAA0000) together with lw_valid (rd=8, data 0x1234) -> rf_wa=3, rf_wd=0xAAAA0000, lw_ready=0. Next cycle sw_valid=0 -> rf_wa=8, rf_wd=0x1234, lw_ready=1.
- Hold sw_valid=1 and lw_valid=1 for 8 cycles -> iss_ready=0 from cycle 9 until lw handshake, then iss_ready returns 1.
- lw handshake with lw_rd=12, pending[12]=0 -> err=1 and held. lw with rd=0 -> rf_we=0, outstanding-1. Assert rst_n=0 mid-stream -> all state clears immediately, err=0.
